// File: rtl/bus_arbiter_pkg.sv
// Shared types for the C64 bus arbiter: FSM states and phi2 grant codes.
// Grant codes double as the select for the address/data muxes.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WARN  = 2'd1,
        STEAL = 2'd2,
        EXT   = 2'd3
    } state_e;

    localparam logic [1:0] GRANT_CPU = 2'd0;
    localparam logic [1:0] GRANT_VIC = 2'd1;
    localparam logic [1:0] GRANT_EXT = 2'd2;

endpackage

// File: rtl/bus_arbiter_if.sv
// DMA request inputs and bus-phase/ownership outputs of the arbiter.
// master = arbiter side, slave = requesters and pla/mux consumers.
interface bus_arbiter_if;

    logic       dma_req_vic;
    logic       dma_req_ext;
    logic       phi2;
    logic       ba;
    logic       aec;
    logic       cpu_rdy;
    logic [1:0] grant;

    modport master (
        input  dma_req_vic,
        input  dma_req_ext,
        output phi2,
        output ba,
        output aec,
        output cpu_rdy,
        output grant
    );

    modport slave (
        output dma_req_vic,
        output dma_req_ext,
        input  phi2,
        input  ba,
        input  aec,
        input  cpu_rdy,
        input  grant
    );

endinterface

// File: rtl/bus_arbiter.sv
// C64 system-bus arbiter: phi2 phase generator, CPU/VIC/EXT ownership FSM, BA lead counter.
// Requests are sampled only at the end of phi2; all outputs are registered and move with the following phi1.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int BA_LEAD = 3
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.master bus
);

    if (BA_LEAD < 1 || BA_LEAD > 7) begin : g_bad_lead
        $error("bus_arbiter: BA_LEAD must be in 1..7");
    end

    localparam logic [2:0] LEAD = 3'(BA_LEAD);

    logic       r_run;
    logic       r_phi2;
    logic       r_aec;
    logic       r_ba;
    logic       r_rdy;
    logic [1:0] r_grant;
    logic [2:0] r_cnt;
    state_e     r_state;

    logic       w_decide;
    logic       w_phi2_nxt;
    logic [2:0] w_cnt_dec;
    logic [2:0] w_cnt_nxt;
    state_e     w_state_nxt;
    logic       w_ba_nxt;
    logic       w_rdy_nxt;
    logic [1:0] w_grant_nxt;

    // r_run holds phi2 low for one extra tick after reset so the first phi1 is a full half.
    assign w_decide   = r_run & r_phi2;
    assign w_phi2_nxt = r_run & ~r_phi2;
    assign w_cnt_dec  = (r_cnt == 3'd0) ? 3'd0 : r_cnt - 3'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.dma_req_vic) begin
                    w_state_nxt = WARN;
                    w_cnt_nxt   = LEAD;
                end else if (bus.dma_req_ext) begin
                    w_state_nxt = EXT;
                end
            end
            WARN: begin
                w_cnt_nxt = w_cnt_dec;
                if (!bus.dma_req_vic) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 3'd0;
                end else if (w_cnt_dec == 3'd0) begin
                    w_state_nxt = STEAL;
                end
            end
            STEAL: begin
                if (!bus.dma_req_vic) begin
                    w_state_nxt = IDLE;
                end
            end
            EXT: begin
                // CPU is already off the bus, so the VIC needs no BA lead here.
                if (bus.dma_req_vic) begin
                    w_state_nxt = STEAL;
                end else if (!bus.dma_req_ext) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ba_nxt    = 1'b1;
        w_rdy_nxt   = 1'b1;
        w_grant_nxt = GRANT_CPU;
        case (w_state_nxt)
            WARN: begin
                w_ba_nxt  = 1'b0;
                w_rdy_nxt = 1'b0;
            end
            STEAL: begin
                w_ba_nxt    = 1'b0;
                w_rdy_nxt   = 1'b0;
                w_grant_nxt = GRANT_VIC;
            end
            EXT: begin
                w_rdy_nxt   = 1'b0;
                w_grant_nxt = GRANT_EXT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run   <= 1'b0;
            r_phi2  <= 1'b0;
            r_aec   <= 1'b0;
            r_ba    <= 1'b1;
            r_rdy   <= 1'b1;
            r_grant <= GRANT_CPU;
            r_cnt   <= 3'd0;
            r_state <= IDLE;
        end else begin
            r_run  <= 1'b1;
            r_phi2 <= w_phi2_nxt;
            // Grant only changes on a phi2->phi1 edge, where aec is forced low anyway.
            r_aec  <= w_phi2_nxt & (r_grant == GRANT_CPU);
            if (w_decide) begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_ba    <= w_ba_nxt;
                r_rdy   <= w_rdy_nxt;
                r_grant <= w_grant_nxt;
            end
        end
    end

    assign bus.phi2    = r_phi2;
    assign bus.aec     = r_aec;
    assign bus.ba      = r_ba;
    assign bus.cpu_rdy = r_rdy;
    assign bus.grant   = r_grant;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with BA_LEAD=3; expectations are hand-computed per bus cycle.
module tb_bus_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic       p1_phi2, p1_aec, p1_ba, p1_rdy;
    logic [1:0] p1_grant;
    logic       p2_phi2, p2_aec, p2_ba, p2_rdy;
    logic [1:0] p2_grant;

    bus_arbiter_if bif ();

    bus_arbiter #(.BA_LEAD(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called from the phi2 half; advances one bus cycle and captures both halves.
    task automatic bus_cycle();
        step();
        p1_phi2 = bif.phi2; p1_aec = bif.aec; p1_ba = bif.ba;
        p1_rdy = bif.cpu_rdy; p1_grant = bif.grant;
        step();
        p2_phi2 = bif.phi2; p2_aec = bif.aec; p2_ba = bif.ba;
        p2_rdy = bif.cpu_rdy; p2_grant = bif.grant;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bif.dma_req_vic = 1'b0;
        bif.dma_req_ext = 1'b0;
        #2 rst = 1'b1;
        step();
        total++;
        if ({bif.phi2, bif.ba, bif.aec, bif.cpu_rdy, bif.grant} !== 6'b010100) begin
            bad++;
            $display("FAIL reset_vals got=%b exp=010100",
                     {bif.phi2, bif.ba, bif.aec, bif.cpu_rdy, bif.grant});
        end
        rst = 1'b0;
        step();
        total++;
        if (bif.phi2 !== 1'b0) begin
            bad++; $display("FAIL rel_first_edge phi2 got=%b exp=0", bif.phi2);
        end
        step();
        total++;
        if (bif.phi2 !== 1'b1 || bif.aec !== 1'b1) begin
            bad++; $display("FAIL rel_second_edge phi2/aec got=%b%b exp=11", bif.phi2, bif.aec);
        end
        for (int i = 0; i < 3; i++) begin
            bus_cycle();
            total++;
            if (p1_phi2 !== 1'b0 || p1_aec !== 1'b0 || p2_phi2 !== 1'b1 || p2_aec !== 1'b1) begin
                bad++;
                $display("FAIL idle_phase cyc=%0d got=%b%b%b%b exp=0011", i, p1_phi2, p1_aec, p2_phi2, p2_aec);
            end
        end
        // Mid-cycle reset while phi2=1.
        #3 rst = 1'b1;
        #1;
        total++;
        if ({bif.phi2, bif.ba, bif.aec, bif.cpu_rdy, bif.grant} !== 6'b010100) begin
            bad++;
            $display("FAIL midcycle_reset got=%b exp=010100",
                     {bif.phi2, bif.ba, bif.aec, bif.cpu_rdy, bif.grant});
        end
        step();
        rst = 1'b0;
        step();
        step();
        total++;
        if (bif.phi2 !== 1'b1) begin
            bad++; $display("FAIL rerelease phi2 got=%b exp=1", bif.phi2);
        end
    endtask

    task automatic test_vic_steal();
        bif.dma_req_vic = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            bus_cycle();
            if (i == 6) bif.dma_req_vic = 1'b0;
            total++;
            if (p1_ba !== 1'b0 || p1_rdy !== 1'b0 || p1_aec !== 1'b0) begin
                bad++; $display("FAIL steal_ba_rdy cyc=%0d ba=%b rdy=%b aec1=%b exp=000", i, p1_ba, p1_rdy, p1_aec);
            end
            total++;
            if (p2_aec !== (i <= 3)) begin
                bad++; $display("FAIL steal_aec cyc=%0d got=%b exp=%b", i, p2_aec, (i <= 3));
            end
            total++;
            if (p2_grant !== ((i <= 3) ? 2'd0 : 2'd1)) begin
                bad++; $display("FAIL steal_grant cyc=%0d got=%0d exp=%0d", i, p2_grant, (i <= 3) ? 0 : 1);
            end
        end
        bus_cycle();
        total++;
        if (p1_ba !== 1'b1 || p1_rdy !== 1'b1 || p2_aec !== 1'b1 || p2_grant !== 2'd0) begin
            bad++;
            $display("FAIL steal_release ba=%b rdy=%b aec=%b grant=%0d exp=1 1 1 0", p1_ba, p1_rdy, p2_aec, p2_grant);
        end
    endtask

    task automatic test_abort_warn();
        bif.dma_req_vic = 1'b1;
        bus_cycle();
        bif.dma_req_vic = 1'b0;
        total++;
        if (p1_ba !== 1'b0 || p2_aec !== 1'b1 || p2_grant !== 2'd0) begin
            bad++; $display("FAIL abort_warn ba=%b aec=%b grant=%0d exp=0 1 0", p1_ba, p2_aec, p2_grant);
        end
        for (int i = 0; i < 2; i++) begin
            bus_cycle();
            total++;
            if (p1_ba !== 1'b1 || p1_rdy !== 1'b1 || p2_aec !== 1'b1 || p2_grant !== 2'd0) begin
                bad++;
                $display("FAIL abort_after cyc=%0d ba=%b rdy=%b aec=%b grant=%0d exp=1 1 1 0", i, p1_ba, p1_rdy, p2_aec, p2_grant);
            end
        end
    endtask

    task automatic test_priority_and_preempt();
        bif.dma_req_vic = 1'b1;
        bif.dma_req_ext = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus_cycle();
            total++;
            if (p2_grant !== ((i <= 3) ? 2'd0 : 2'd1) || p2_ba !== 1'b0) begin
                bad++; $display("FAIL prio cyc=%0d grant=%0d ba=%b exp=%0d 0", i, p2_grant, p2_ba, (i <= 3) ? 0 : 1);
            end
        end
        bif.dma_req_vic = 1'b0;
        bus_cycle();
        total++;
        if (p2_grant !== 2'd0 || p2_ba !== 1'b1 || p2_rdy !== 1'b1 || p2_aec !== 1'b1) begin
            bad++; $display("FAIL prio_idle grant=%0d ba=%b rdy=%b aec=%b exp=0 1 1 1", p2_grant, p2_ba, p2_rdy, p2_aec);
        end
        bus_cycle();
        total++;
        if (p2_grant !== 2'd2 || p2_ba !== 1'b1 || p2_rdy !== 1'b0 || p2_aec !== 1'b0 || p1_aec !== 1'b0) begin
            bad++; $display("FAIL prio_ext grant=%0d ba=%b rdy=%b aec=%b exp=2 1 0 0", p2_grant, p2_ba, p2_rdy, p2_aec);
        end
        bif.dma_req_vic = 1'b1;
        bus_cycle();
        total++;
        if (p1_grant !== 2'd1 || p1_ba !== 1'b0 || p2_aec !== 1'b0) begin
            bad++; $display("FAIL preempt grant=%0d ba=%b aec=%b exp=1 0 0", p1_grant, p1_ba, p2_aec);
        end
        bif.dma_req_vic = 1'b0;
        bif.dma_req_ext = 1'b0;
        bus_cycle();
        total++;
        if (p2_grant !== 2'd0 || p2_ba !== 1'b1 || p2_rdy !== 1'b1) begin
            bad++; $display("FAIL preempt_release grant=%0d ba=%b rdy=%b exp=0 1 1", p2_grant, p2_ba, p2_rdy);
        end
    endtask

    task automatic test_glitch();
        step();
        bif.dma_req_ext = 1'b1;
        step();
        bif.dma_req_ext = 1'b0;
        bus_cycle();
        total++;
        if (p2_grant !== 2'd0 || p2_rdy !== 1'b1 || p2_aec !== 1'b1) begin
            bad++; $display("FAIL glitch grant=%0d rdy=%b aec=%b exp=0 1 1", p2_grant, p2_rdy, p2_aec);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_vic_steal();
        test_abort_warn();
        test_priority_and_preempt();
        test_glitch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
